// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: conversion responder for an 8-channel 12-bit SPI ADC.
// Each accepted strt_cnv runs two 16-bit SPI frames. Both frames select the latched
// channel, and the second frame returns the conversion result. The 12-bit result is then
// published on A2D_res, and cnv_cmplt is raised.
module a2d_spi_resp #(
    parameter int unsigned SCLK_DIV = 32,
    parameter int unsigned FRM_BITS = 16,
    parameter int unsigned GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        cnv_cmplt,
    output logic [11:0] A2D_res
);

    localparam int unsigned DW = $clog2(SCLK_DIV);
    localparam int unsigned BW = $clog2(FRM_BITS + 1);
    localparam int unsigned GW = $clog2(GAP_CLKS + 1);

    // Load value puts SCLK high on entry, with the first fall 9 clocks later.
    localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV * 3 / 4 - 1);
    localparam logic [DW-1:0] DIV_RISE = DW'(SCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX1,
        GAP,
        TX2,
        DONE
    } state_t;

    state_t        state;
    logic [2:0]    ch_lat;
    logic [15:0]   shft;
    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [BW-1:0] bitcnt;
    logic [GW-1:0] gap_cnt;
    logic          frame_end;

    // Divider look-ahead. The frame closes on the edge where the divider reaches its last
    // count after the final bit. SCLK is therefore still high there, and no trailing fall
    // is produced.
    always_comb begin
        div_nxt   = div + DW'(1);
        frame_end = (div_nxt == DIV_LAST) && (bitcnt == BW'(FRM_BITS));
    end

    // SCLK follows the divider MSB only while selected. It idles high otherwise.
    always_comb begin
        SCLK = SS_n | div[DW-1];
        MOSI = ~SS_n & shft[15];
    end

    // Conversion sequencer: IDLE -> TX1 -> GAP -> TX2 -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_lat    <= 3'd0;
            shft      <= 16'h0000;
            div       <= '0;
            bitcnt    <= '0;
            gap_cnt   <= '0;
            SS_n      <= 1'b1;
            cnv_cmplt <= 1'b0;
            A2D_res   <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (strt_cnv) begin
                        ch_lat    <= chnnl;
                        cnv_cmplt <= 1'b0;
                        state     <= TX1;
                    end
                end
                TX1, TX2: begin
                    if (SS_n) begin
                        // First clock of TX1: start the frame one edge after acceptance.
                        shft   <= {2'b00, ch_lat, 11'h000};
                        div    <= DIV_LOAD;
                        bitcnt <= '0;
                        SS_n   <= 1'b0;
                    end else if (frame_end) begin
                        SS_n    <= 1'b1;
                        div     <= '0;
                        bitcnt  <= '0;
                        gap_cnt <= '0;
                        state   <= (state == TX1) ? GAP : DONE;
                    end else begin
                        div <= div_nxt;
                        if (div == DIV_RISE) begin
                            shft   <= {shft[14:0], MISO};
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CLKS - 1)) begin
                        shft   <= {2'b00, ch_lat, 11'h000};
                        div    <= DIV_LOAD;
                        bitcnt <= '0;
                        SS_n   <= 1'b0;
                        state  <= TX2;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    A2D_res   <= shft[11:0];
                    cnv_cmplt <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Testbench for a2d_spi_resp: ADC model on the SPI pins, a frame-shape monitor, and
// table-driven conversions plus a hand-written mid-frame reset sequence.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;

    int errors = 0;
    int checks = 0;

    a2d_spi_resp dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res)
    );

    always #5 clk = ~clk;

    // ADC model: returns {4'hB, value} of the channel selected in the previous frame.
    logic [11:0] adc_val [8];
    logic [2:0]  last_ch = 3'd0;
    int          miso_cnt = 0;
    logic [15:0] miso_word;

    always_comb begin
        miso_word = {4'hB, adc_val[last_ch]};
        MISO      = (miso_cnt < 16) ? miso_word[4'(15 - miso_cnt)] : 1'b0;
    end

    // Frame monitor, sampled on the falling edge.
    logic        prev_sclk = 1'b1;
    logic        prev_ss   = 1'b1;
    logic        prev_mosi = 1'b0;
    logic        start_ok  = 1'b0;
    int          rises     = 0;
    int          low_clks  = 0;
    int          high_clks = 0;
    logic [15:0] mosi_word = 16'h0;
    int          f_rises [$];
    int          f_low   [$];
    logic [15:0] f_mosi  [$];
    bit          f_edge  [$];
    int          gaps    [$];

    always @(negedge clk) begin
        prev_sclk <= SCLK;
        prev_ss   <= SS_n;
        prev_mosi <= MOSI;
        if (!SS_n) begin
            if (prev_ss) begin
                gaps.push_back(high_clks);
                low_clks  <= 1;
                rises     <= 0;
                mosi_word <= 16'h0;
                miso_cnt  <= 0;
                start_ok  <= SCLK && prev_sclk;
            end else begin
                low_clks <= low_clks + 1;
                if (!prev_sclk && SCLK) begin
                    rises     <= rises + 1;
                    mosi_word <= {mosi_word[14:0], prev_mosi};
                    miso_cnt  <= miso_cnt + 1;
                end
            end
        end else begin
            if (!prev_ss) begin
                f_rises.push_back(rises);
                f_low.push_back(low_clks);
                f_mosi.push_back(mosi_word);
                f_edge.push_back(start_ok && SCLK && prev_sclk);
                last_ch   <= mosi_word[13:11];
                high_clks <= 1;
            end else begin
                high_clks <= high_clks + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
        int          idle;
        bit          repulse;
        bit          toggle;
        logic [11:0] exp_res;
        int          exp_lat;
    } rec_t;

    task automatic run_conv(input rec_t v);
        int          lat;
        int          fall_at;
        logic [15:0] exp_word;
        exp_word = {2'b00, v.ch, 11'h000};
        adc_val[v.ch] = v.val;
        repeat (v.idle) @(negedge clk);
        @(negedge clk);
        f_rises.delete();
        f_low.delete();
        f_mosi.delete();
        f_edge.delete();
        gaps.delete();
        strt_cnv = 1'b1;
        chnnl    = v.ch;
        @(negedge clk);
        strt_cnv = 1'b0;
        chk("cmplt_clr", {31'd0, cnv_cmplt}, 32'd0);
        chk("ss_high_e0", {31'd0, SS_n}, 32'd1);
        if (v.toggle) chnnl = 3'($urandom_range(0, 7));
        lat     = -1;
        fall_at = -1;
        for (int n = 1; n <= 2000 && lat < 0; n++) begin
            @(negedge clk);
            if (fall_at < 0 && !SS_n) fall_at = n;
            if (cnv_cmplt) lat = n;
            strt_cnv = v.repulse && (n == 700);
            if (v.repulse && n == 700) chnnl = 3'd7;
            else if (v.toggle) chnnl = 3'($urandom_range(0, 7));
        end
        strt_cnv = 1'b0;
        chk("latency", lat, v.exp_lat);
        chk("ss_fall_edge", fall_at, 1);
        chk("result", {20'd0, A2D_res}, {20'd0, v.exp_res});
        chk("frame_count", f_rises.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (f_rises.size() > i) begin
                chk("sclk_rises", f_rises[i], 16);
                chk("ss_low_clks", f_low[i], 520);
                chk("mosi_word", {16'd0, f_mosi[i]}, {16'd0, exp_word});
                chk("sclk_high_at_ss", {31'd0, f_edge[i]}, 32'd1);
            end
        end
        if (gaps.size() > 1) chk("gap_clks", gaps[1], 32);
        else chk("gap_seen", gaps.size(), 2);
        if (v.repulse) begin
            repeat (40) @(negedge clk);
            chk("cmplt_hold", {31'd0, cnv_cmplt}, 32'd1);
            chk("no_restart", f_rises.size(), 2);
            chk("result_hold", {20'd0, A2D_res}, {20'd0, v.exp_res});
        end
    endtask

    rec_t vecs [9];
    rec_t rec_after;
    bit   quiet;

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 12'hE00 + 12'(i);
        vecs[0] = '{ch: 3'h4, val: 12'hA5C, idle: 3, repulse: 0, toggle: 0,
                    exp_res: 12'hA5C, exp_lat: 1074};
        vecs[1] = '{ch: 3'h1, val: 12'h100, idle: 0, repulse: 0, toggle: 0,
                    exp_res: 12'h100, exp_lat: 1074};
        vecs[2] = '{ch: 3'h0, val: 12'h200, idle: 0, repulse: 0, toggle: 0,
                    exp_res: 12'h200, exp_lat: 1074};
        vecs[3] = '{ch: 3'h4, val: 12'h300, idle: 0, repulse: 0, toggle: 0,
                    exp_res: 12'h300, exp_lat: 1074};
        vecs[4] = '{ch: 3'h2, val: 12'h400, idle: 0, repulse: 0, toggle: 0,
                    exp_res: 12'h400, exp_lat: 1074};
        vecs[5] = '{ch: 3'h3, val: 12'h500, idle: 0, repulse: 0, toggle: 0,
                    exp_res: 12'h500, exp_lat: 1074};
        vecs[6] = '{ch: 3'h7, val: 12'h600, idle: 0, repulse: 0, toggle: 0,
                    exp_res: 12'h600, exp_lat: 1074};
        vecs[7] = '{ch: 3'h5, val: 12'h7E1, idle: 5, repulse: 1, toggle: 0,
                    exp_res: 12'h7E1, exp_lat: 1074};
        vecs[8] = '{ch: 3'h2, val: 12'h3C9, idle: 2, repulse: 0, toggle: 1,
                    exp_res: 12'h3C9, exp_lat: 1074};
        rec_after = '{ch: 3'h6, val: 12'h0F3, idle: 4, repulse: 0, toggle: 0,
                      exp_res: 12'h0F3, exp_lat: 1074};

        rst      = 1'b1;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
        chk("rst_sclk", {31'd0, SCLK}, 32'd1);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        chk("rst_res", {20'd0, A2D_res}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_conv(vecs[i]);

        // Reset in the middle of frame 1 aborts everything, including the held result.
        @(negedge clk);
        strt_cnv = 1'b1;
        chnnl    = 3'h5;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (200) @(negedge clk);
        chk("mid_tx1_ss_low", {31'd0, SS_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ss_n", {31'd0, SS_n}, 32'd1);
        chk("abort_sclk", {31'd0, SCLK}, 32'd1);
        chk("abort_mosi", {31'd0, MOSI}, 32'd0);
        chk("abort_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        chk("abort_res", {20'd0, A2D_res}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        quiet = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!SCLK || !SS_n) quiet = 1'b0;
        end
        chk("quiet_after_rst", {31'd0, quiet}, 32'd1);

        run_conv(rec_after);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
